cycle_sequencer: RTL and testbench
==================================

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64, meaning max wait cycles for any memory handshake (range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_done  input  1  instruction memory has returned instr this cycle.
REQ-005 SHALL have port dmem_done  input  1  data memory access complete this cycle.
REQ-006 SHALL have ports ctl_regwrite, ctl_memwrite, ctl_memtoreg, ctl_halt  input  1 each  class bits from the control unit for the current instruction.
REQ-007 SHALL have port rf_err  input  1  register file error flag.
REQ-008 SHALL have ports imem_req, ir_write, dmem_req, dmem_wr, rf_write, pc_write  output  1 each  datapath enables.
REQ-009 SHALL have ports halted, err  output  1 each  sticky terminal status.
REQ-010 SHALL have port state  output  3  current state encoding.
REQ-011 SHALL have port instr_count  output  16  retired-instruction counter.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-013 FETCH: imem_req=1; on imem_done, ir_write=1 same cycle, next DECODE; else stay.
REQ-014 DECODE: one cycle; ctl_halt=1 -> HALT, else -> EXEC.
REQ-015 EXEC: one cycle; ctl_memwrite|ctl_memtoreg -> MEM; else ctl_regwrite -> WB; else pc_write=1, -> FETCH.
REQ-016 MEM: dmem_req=1, dmem_wr=ctl_memwrite; on dmem_done: ctl_memtoreg -> WB, else pc_write=1, -> FETCH.
REQ-017 WB: one cycle; rf_write=1, pc_write=1, -> FETCH.
REQ-018 ctl_memwrite and ctl_memtoreg both 1 in EXEC SHALL be treated as error -> ERR, no memory request issued.
REQ-019 rf_err=1 in any non-terminal state SHALL force next state ERR; no enable asserted that cycle except already-decoded imem_req/dmem_req.
REQ-020 Wait counter (8 bit) SHALL clear on entry to FETCH or MEM, increment each cycle waiting without done; reaching MEM_TIMEOUT -> ERR.
REQ-021 done asserted on the same cycle the counter reaches MEM_TIMEOUT SHALL win (normal transition).
REQ-022 HALT: halted=1, all enables 0, stays until reset; ERR: err=1, all enables 0, stays until reset.
REQ-023 instr_count SHALL increment by 1 on every cycle pc_write=1, wrapping 0xFFFF -> 0x0000; HALT does not count.
REQ-024 All outputs SHALL be decoded from registered state plus current inputs; no output depends on another output.
REQ-025 Minimum latency: ALU no-writeback 3 cycles, ALU writeback 4, store 4, load 5 (done on first cycle of each wait).

Reset
REQ-026 rst=0 SHALL asynchronously force state FETCH, wait counter 0, instr_count 0, halted 0, err 0.
REQ-027 During reset all enables SHALL be 0; imem_req rises the first cycle after rst deasserts.
REQ-028 Reset mid-MEM SHALL drop dmem_req immediately with no write completion required.

Structure
REQ-029 State encodings (3 bit) and default MEM_TIMEOUT SHALL live in shared package seq_pkg.
REQ-030 Wait counter SHALL be sub-module mem_timeout_ctr (clear, enable, limit in; expired out).

Verification
REQ-031 ALU op, ctl_regwrite=1, imem_done first cycle -> states FETCH,DECODE,EXEC,WB; rf_write and pc_write in cycle 4; instr_count=1.
REQ-032 Store, dmem_done 3 cycles after MEM entry -> dmem_req=1, dmem_wr=1 for 3 cycles, pc_write on done cycle, no rf_write.
REQ-033 ctl_halt=1 in DECODE -> HALT, halted=1, instr_count unchanged, no enables for 10 further cycles.
REQ-034 imem_done held 0 -> ERR after 64 FETCH cycles, err=1; repeat with done on cycle 64 -> DECODE, err=0.
REQ-035 Reset asserted mid-MEM of load -> dmem_req 0 same cycle, state FETCH, instr_count 0 after release.
REQ-036 Preload via 65535 retired instructions, retire one more -> instr_count wraps to 0x0000.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
// State encodings are visible on the state output and must stay stable.
package seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } seq_state_e;

    localparam int unsigned SEQ_MEM_TIMEOUT = 64;
    localparam int unsigned SEQ_WAIT_W      = 8;

    function automatic logic is_wait(input seq_state_e s);
        return (s == S_FETCH) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Control-unit / memory / datapath bundle around the cycle sequencer.
// master = sequencer side, slave = datapath side.
interface cycle_sequencer_if;

    logic        imem_done;
    logic        dmem_done;
    logic        ctl_regwrite;
    logic        ctl_memwrite;
    logic        ctl_memtoreg;
    logic        ctl_halt;
    logic        rf_err;

    logic        imem_req;
    logic        ir_write;
    logic        dmem_req;
    logic        dmem_wr;
    logic        rf_write;
    logic        pc_write;
    logic        halted;
    logic        err;
    logic [2:0]  state;
    logic [15:0] instr_count;

    modport master (
        input  imem_done, dmem_done,
        input  ctl_regwrite, ctl_memwrite, ctl_memtoreg, ctl_halt,
        input  rf_err,
        output imem_req, ir_write, dmem_req, dmem_wr, rf_write, pc_write,
        output halted, err, state, instr_count
    );

    modport slave (
        output imem_done, dmem_done,
        output ctl_regwrite, ctl_memwrite, ctl_memtoreg, ctl_halt,
        output rf_err,
        input  imem_req, ir_write, dmem_req, dmem_wr, rf_write, pc_write,
        input  halted, err, state, instr_count
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for memory handshakes; flags the cycle that would
// bring the count up to the limit so the sequencer can abandon the wait.
module mem_timeout_ctr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of enable so the caller can gate it without a comb loop
    assign expired_o = ({1'b0, cnt_q} + (W + 1)'(1)) >= {1'b0, limit_i};

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with handshake timeouts,
// sticky HALT/ERR terminal states and a retired-instruction counter.
module cycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = SEQ_MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    cycle_sequencer_if.master     bus
);

    localparam logic [SEQ_WAIT_W-1:0] LIMIT = SEQ_WAIT_W'(MEM_TIMEOUT);

    seq_state_e  state_q;
    seq_state_e  state_d;
    logic [15:0] icnt_q;
    logic [15:0] icnt_d;

    logic imem_req;
    logic ir_write;
    logic dmem_req;
    logic dmem_wr;
    logic rf_write;
    logic pc_write;
    logic wait_en;
    logic wait_clr;
    logic expired;

    assign wait_en = ((state_q == S_FETCH) && !bus.imem_done)
                  || ((state_q == S_MEM) && !bus.dmem_done);
    assign wait_clr = !is_wait(state_q);

    mem_timeout_ctr #(
        .W(SEQ_WAIT_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wait_clr),
        .enable_i  (wait_en),
        .limit_i   (LIMIT),
        .expired_o (expired)
    );

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_write = 1'b0;
        dmem_req = 1'b0;
        dmem_wr  = 1'b0;
        rf_write = 1'b0;
        pc_write = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_done) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                state_d = bus.ctl_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (bus.ctl_memwrite && bus.ctl_memtoreg) begin
                    state_d = S_ERR;
                end else if (bus.ctl_memwrite || bus.ctl_memtoreg) begin
                    state_d = S_MEM;
                end else if (bus.ctl_regwrite) begin
                    state_d = S_WB;
                end else begin
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_wr  = bus.ctl_memwrite;
                if (bus.dmem_done) begin
                    if (bus.ctl_memtoreg) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                rf_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT, S_ERR: begin
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
        // Register-file fault wins; only the in-flight memory requests stay up
        if (bus.rf_err && (state_q != S_HALT) && (state_q != S_ERR)) begin
            ir_write = 1'b0;
            dmem_wr  = 1'b0;
            rf_write = 1'b0;
            pc_write = 1'b0;
            state_d  = S_ERR;
        end
    end

    always_comb begin
        icnt_d = icnt_q;
        if (pc_write) begin
            icnt_d = icnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            icnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
        end
    end

    assign bus.imem_req    = rst & imem_req;
    assign bus.ir_write    = rst & ir_write;
    assign bus.dmem_req    = rst & dmem_req;
    assign bus.dmem_wr     = rst & dmem_wr;
    assign bus.rf_write    = rst & rf_write;
    assign bus.pc_write    = rst & pc_write;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.err         = (state_q == S_ERR);
    assign bus.state       = state_q;
    assign bus.instr_count = icnt_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: instruction-level script expands into expected
// per-cycle outputs, checked every cycle at the falling edge.
module tb_cycle_sequencer;
    import seq_pkg::*;

    localparam int T = 64;
    localparam int K_ALU   = 0;
    localparam int K_ALUWB = 1;
    localparam int K_ST    = 2;
    localparam int K_LD    = 3;
    localparam int K_BAD   = 4;
    localparam int K_HALT  = 5;

    typedef struct {
        logic        idn, ddn, rw, mw, mr, hin, rfe, rs;
        logic [5:0]  en;
        logic        hl, er;
        logic [2:0]  st;
        logic [15:0] cnt;
        bit          lon;
        logic [15:0] lcnt;
        logic [2:0]  lst;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cycle_sequencer_if bus ();

    cycle_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    cyc_t        expq[$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc_n = 0;
    logic [15:0] m_cnt;
    logic [2:0]  m_term;
    bit          ab;
    int          k, rfe_g, rst_g;
    logic        c_rw, c_mw, c_mr, c_hl;
    bit          pend_on;
    logic [15:0] pend_cnt;
    logic [2:0]  pend_st;
    bit          pl_on;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic emit(input cyc_t c);
        @(posedge clk);
        #1;
        if (pl_on) begin
            force dut.icnt_q = 16'hFFFE;
            #1;
            release dut.icnt_q;
            pl_on = 0;
        end
        rst              = c.rs;
        bus.imem_done    = c.idn;
        bus.dmem_done    = c.ddn;
        bus.ctl_regwrite = c.rw;
        bus.ctl_memwrite = c.mw;
        bus.ctl_memtoreg = c.mr;
        bus.ctl_halt     = c.hin;
        bus.rf_err       = c.rfe;
        c.lon  = pend_on;
        c.lcnt = pend_cnt;
        c.lst  = pend_st;
        pend_on = 0;
        expq.push_back(c);
    endtask

    task automatic pin(input logic [15:0] cnt, input logic [2:0] st);
        pend_on  = 1;
        pend_cnt = cnt;
        pend_st  = st;
    endtask

    // One cycle of a live instruction, with optional rf_err or reset injection
    task automatic put(input logic [2:0] st, input logic idn, input logic ddn,
                       input logic [5:0] en);
        cyc_t c;
        c.idn = idn; c.ddn = ddn;
        c.rw = c_rw; c.mw = c_mw; c.mr = c_mr; c.hin = c_hl;
        c.rfe = 0; c.rs = 1; c.hl = 0; c.er = 0;
        c.st = st; c.cnt = m_cnt; c.en = en;
        if (k == rst_g) begin
            c.rs = 0; c.en = '0; c.st = S_FETCH; c.cnt = '0;
            m_cnt = '0; m_term = '0; ab = 1;
        end else if (k == rfe_g) begin
            c.rfe = 1; c.en = en & 6'b101000;
            m_term = S_ERR; ab = 1;
        end else if (en[0]) begin
            m_cnt = m_cnt + 16'd1;
        end
        emit(c);
        k++;
    endtask

    task automatic wph(input logic [2:0] st, input bit imem, input int n,
                       input logic [5:0] ew, input logic [5:0] ed);
        for (int i = 0; i < n && i < T; i++) begin
            if (imem) put(st, 1'b0, rb(), ew);
            else      put(st, rb(), 1'b0, ew);
            if (ab) return;
        end
        if (n >= T) begin
            m_term = S_ERR;
            ab = 1;
            return;
        end
        if (imem) put(st, 1'b1, rb(), ed);
        else      put(st, rb(), 1'b1, ed);
    endtask

    task automatic instr(input int kind, input int fw, input int mw,
                         input int rfe_at, input int rst_at);
        k = 0; ab = 0; rfe_g = rfe_at; rst_g = rst_at;
        c_hl = (kind == K_HALT);
        case (kind)
            K_ALU:   {c_rw, c_mw, c_mr} = 3'b000;
            K_ALUWB: {c_rw, c_mw, c_mr} = 3'b100;
            K_ST:    {c_rw, c_mw, c_mr} = {rb(), 1'b1, 1'b0};
            K_LD:    {c_rw, c_mw, c_mr} = {rb(), 1'b0, 1'b1};
            K_BAD:   {c_rw, c_mw, c_mr} = {rb(), 1'b1, 1'b1};
            default: {c_rw, c_mw, c_mr} = {rb(), rb(), rb()};
        endcase
        wph(S_FETCH, 1, fw, 6'b100000, 6'b110000);
        if (ab) return;
        put(S_DECODE, rb(), rb(), 6'b0);
        if (ab) return;
        if (c_hl) begin
            m_term = S_HALT;
            return;
        end
        put(S_EXEC, rb(), rb(), (kind == K_ALU) ? 6'b000001 : 6'b0);
        if (ab) return;
        case (kind)
            K_ALUWB: put(S_WB, rb(), rb(), 6'b000011);
            K_BAD:   m_term = S_ERR;
            K_ST:    wph(S_MEM, 0, mw, 6'b001100, 6'b001101);
            K_LD: begin
                wph(S_MEM, 0, mw, 6'b001000, 6'b001000);
                if (ab) return;
                put(S_WB, rb(), rb(), 6'b000011);
            end
            default: ;
        endcase
    endtask

    task automatic term(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_t c;
            c.idn = rb(); c.ddn = rb(); c.rw = rb(); c.mw = rb();
            c.mr = rb(); c.hin = rb(); c.rfe = rb(); c.rs = 1;
            c.en = '0; c.st = m_term; c.cnt = m_cnt;
            c.hl = (m_term == S_HALT);
            c.er = (m_term == S_ERR);
            emit(c);
        end
    endtask

    task automatic do_rst(input int n);
        m_cnt = '0;
        m_term = '0;
        for (int i = 0; i < n; i++) begin
            cyc_t c;
            c.idn = rb(); c.ddn = rb(); c.rw = rb(); c.mw = rb();
            c.mr = rb(); c.hin = rb(); c.rfe = rb(); c.rs = 0;
            c.en = '0; c.st = S_FETCH; c.cnt = '0; c.hl = 0; c.er = 0;
            emit(c);
        end
    endtask

    task automatic fin();
        if (m_term != 3'd0) begin
            term(3);
            do_rst(1);
        end
    endtask

    cyc_t        cc;
    logic [26:0] got, ex;

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            cc  = expq.pop_front();
            got = {bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_wr,
                   bus.rf_write, bus.pc_write, bus.halted, bus.err,
                   bus.state, bus.instr_count};
            ex  = {cc.en, cc.hl, cc.er, cc.st, cc.cnt};
            nvec++;
            if (got !== ex) begin
                nerr++;
                $display("FAIL cyc%0d outputs {en6,halted,err,state,count}: got %h expected %h",
                         cyc_n, got, ex);
            end
            if (cc.lon) begin
                nvec++;
                if ({bus.state, bus.instr_count} !== {cc.lst, cc.lcnt}) begin
                    nerr++;
                    $display("FAIL cyc%0d pinned state/count: got %0d/%h expected %0d/%h",
                             cyc_n, bus.state, bus.instr_count, cc.lst, cc.lcnt);
                end
            end
        end
        cyc_n++;
    end

    initial begin
        int kind, fw, mw, rfe, ra;
        bus.imem_done = 0; bus.dmem_done = 0; bus.ctl_regwrite = 0;
        bus.ctl_memwrite = 0; bus.ctl_memtoreg = 0; bus.ctl_halt = 0;
        bus.rf_err = 0;
        m_cnt = '0; m_term = '0; pend_on = 0; pl_on = 0;
        pend_cnt = '0; pend_st = '0;
        do_rst(2);

        instr(K_ALUWB, 0, 0, -1, -1); pin(16'd1, S_FETCH);
        instr(K_ST, 0, 2, -1, -1);    pin(16'd2, S_FETCH);
        instr(K_ALU, 0, 0, -1, -1);   pin(16'd3, S_FETCH);
        instr(K_LD, 0, 0, -1, -1);    pin(16'd4, S_FETCH);
        instr(K_HALT, 0, 0, -1, -1);  pin(16'd4, S_HALT);
        term(10); do_rst(1);

        instr(K_ALU, 64, 0, -1, -1);  pin(16'd0, S_ERR);
        term(3); do_rst(1);
        instr(K_ALU, 63, 0, -1, -1);  pin(16'd1, S_FETCH);
        instr(K_LD, 1, 64, -1, -1);   pin(16'd1, S_ERR);
        term(2); do_rst(1);
        instr(K_LD, 2, 63, -1, -1);   pin(16'd1, S_FETCH);
        instr(K_BAD, 0, 0, -1, -1);   pin(16'd1, S_ERR);
        term(3); do_rst(1);

        for (int r = 0; r < 9; r++) begin
            instr(K_LD, 1, 1, r, -1);
            fin();
        end
        for (int r = 0; r < 5; r++) begin
            instr(K_ST, 0, 1, r, -1);
            fin();
        end

        instr(K_ALU, 0, 0, -1, -1);
        instr(K_LD, 0, 5, -1, 4);     pin(16'd0, S_FETCH);
        instr(K_ALU, 0, 0, -1, -1);

        pl_on = 1;
        m_cnt = 16'hFFFE;
        instr(K_ALU, 0, 0, -1, -1);   pin(16'hFFFF, S_FETCH);
        instr(K_ALU, 0, 0, -1, -1);   pin(16'h0000, S_FETCH);
        instr(K_ALUWB, 0, 0, -1, -1);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 11);
            if (kind > 5) kind = kind % 4;
            fw  = ($urandom_range(0, 24) == 0) ? $urandom_range(62, 66)
                                               : $urandom_range(0, 3);
            mw  = ($urandom_range(0, 24) == 0) ? $urandom_range(62, 66)
                                               : $urandom_range(0, 3);
            rfe = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1;
            ra  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 8) : -1;
            instr(kind, fw, mw, rfe, ra);
            fin();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
